// File: rtl/max_pool_row.sv
// rtl/max_pool_row.sv - 2x2 stride-2 row max-pool stage feeding the pooled-feature writer.
module max_pool_row #(
  parameter int OCH  = 6,
  parameter int OY   = 14,
  parameter int OX   = 14,
  parameter int F_BW = 8
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       i_run,
  input  logic [$clog2(2*OY)-1:0]    i_iy_idx,
  input  logic [$clog2(OCH)-1:0]     i_ich_idx,
  input  logic [2*OX*F_BW-1:0]       i_ix_row,
  input  logic                       i_wr_idle,
  output logic                       o_idle,
  output logic                       o_n_ready,
  output logic                       o_seq_err,
  output logic                       o_ovf_err,
  output logic                       o_wr_run,
  output logic [$clog2(OY)-1:0]      o_wr_oy_idx,
  output logic [$clog2(OCH)-1:0]     o_wr_och_idx,
  output logic [OX*F_BW-1:0]         o_wr_ox_pool
);

  localparam int IY_W = $clog2(2*OY);
  localparam int CH_W = $clog2(OCH);
  localparam int OY_W = $clog2(OY);

  typedef enum logic [1:0] {S_EVEN, S_ODD, S_PEND} state_t;

  state_t state, state_next;

  logic [OX-1:0][F_BW-1:0] h_max;
  logic [OX-1:0][F_BW-1:0] v_max;
  logic [OX-1:0][F_BW-1:0] r_top;
  logic [OX-1:0][F_BW-1:0] result;
  logic [IY_W-1:0]         top_iy;
  logic [CH_W-1:0]         top_ich;

  logic in_range;
  logic iy_odd;
  logic pair_match;
  logic load_top;
  logic load_result;
  logic issue;
  logic seq_set;
  logic ovf_set;

  for (genvar j = 0; j < OX; j++) begin : g_pool
    logic [F_BW-1:0] left;
    logic [F_BW-1:0] right;
    assign left     = i_ix_row[(2*j)*F_BW +: F_BW];
    assign right    = i_ix_row[(2*j+1)*F_BW +: F_BW];
    assign h_max[j] = (left >= right) ? left : right;
    assign v_max[j] = (h_max[j] >= r_top[j]) ? h_max[j] : r_top[j];
  end

  // Widened compares so the limits still fit when 2*OY or OCH is a power of two.
  assign in_range = ({1'b0, i_iy_idx} < (IY_W+1)'(2*OY)) &&
                    ({1'b0, i_ich_idx} < (CH_W+1)'(OCH));
  assign iy_odd   = i_iy_idx[0];
  // top_iy is always even, so iy == top_iy+1 reduces to matching the upper bits of an odd iy.
  assign pair_match = (i_iy_idx[IY_W-1:1] == top_iy[IY_W-1:1]) && (i_ich_idx == top_ich);

  always_ff @(posedge clk) begin
    if (areset) state <= S_EVEN;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_top    = 1'b0;
    load_result = 1'b0;
    issue       = 1'b0;
    seq_set     = 1'b0;
    ovf_set     = 1'b0;
    case (state)
      S_EVEN: begin
        if (i_run) begin
          if (!in_range || iy_odd) begin
            seq_set = 1'b1;
          end else begin
            load_top   = 1'b1;
            state_next = S_ODD;
          end
        end
      end
      S_ODD: begin
        if (i_run) begin
          if (!in_range) begin
            seq_set = 1'b1;
          end else if (!iy_odd) begin
            seq_set  = 1'b1;
            load_top = 1'b1;
          end else if (pair_match) begin
            load_result = 1'b1;
            state_next  = S_PEND;
          end else begin
            seq_set    = 1'b1;
            state_next = S_EVEN;
          end
        end
      end
      S_PEND: begin
        if (i_wr_idle) begin
          issue      = 1'b1;
          state_next = S_EVEN;
        end
        if (i_run) begin
          ovf_set = 1'b1;
          seq_set = !in_range;
        end
      end
      default: state_next = S_EVEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_top        <= '0;
      top_iy       <= '0;
      top_ich      <= '0;
      result       <= '0;
      o_wr_oy_idx  <= '0;
      o_wr_och_idx <= '0;
      o_wr_run     <= 1'b0;
      o_seq_err    <= 1'b0;
      o_ovf_err    <= 1'b0;
    end else begin
      o_wr_run <= issue;
      if (seq_set) o_seq_err <= 1'b1;
      if (ovf_set) o_ovf_err <= 1'b1;
      if (load_top) begin
        r_top   <= h_max;
        top_iy  <= i_iy_idx;
        top_ich <= i_ich_idx;
      end
      if (load_result) begin
        result       <= v_max;
        o_wr_oy_idx  <= OY_W'(i_iy_idx >> 1);
        o_wr_och_idx <= i_ich_idx;
      end
    end
  end

  assign o_wr_ox_pool = result;
  assign o_n_ready    = (state == S_PEND);
  assign o_idle       = (state == S_EVEN) && !o_wr_run;

endmodule

// File: tb/tb_max_pool_row.sv
// tb/tb_max_pool_row.sv - scoreboard bench for max_pool_row with directed row vectors.
module tb_max_pool_row;

  logic         clk = 1'b0;
  logic         areset;
  logic         i_run;
  logic [4:0]   i_iy_idx;
  logic [2:0]   i_ich_idx;
  logic [223:0] i_ix_row;
  logic         i_wr_idle;
  logic         o_idle;
  logic         o_n_ready;
  logic         o_seq_err;
  logic         o_ovf_err;
  logic         o_wr_run;
  logic [3:0]   o_wr_oy_idx;
  logic [2:0]   o_wr_och_idx;
  logic [111:0] o_wr_ox_pool;

  typedef struct {
    logic [3:0]   oy;
    logic [2:0]   och;
    logic [111:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  max_pool_row dut (
    .clk          (clk),
    .areset       (areset),
    .i_run        (i_run),
    .i_iy_idx     (i_iy_idx),
    .i_ich_idx    (i_ich_idx),
    .i_ix_row     (i_ix_row),
    .i_wr_idle    (i_wr_idle),
    .o_idle       (o_idle),
    .o_n_ready    (o_n_ready),
    .o_seq_err    (o_seq_err),
    .o_ovf_err    (o_ovf_err),
    .o_wr_run     (o_wr_run),
    .o_wr_oy_idx  (o_wr_oy_idx),
    .o_wr_och_idx (o_wr_och_idx),
    .o_wr_ox_pool (o_wr_ox_pool)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [223:0] mk_row(input int base, input int step);
    logic [223:0] r;
    for (int k = 0; k < 28; k++) r[k*8 +: 8] = 8'((base + step*k) & 255);
    return r;
  endfunction

  function automatic logic [111:0] pool4(input logic [223:0] top, input logic [223:0] bot);
    logic [111:0] p;
    for (int j = 0; j < 14; j++) begin
      logic [7:0] m;
      m = top[(2*j)*8 +: 8];
      if (top[(2*j+1)*8 +: 8] > m) m = top[(2*j+1)*8 +: 8];
      if (bot[(2*j)*8 +: 8]   > m) m = bot[(2*j)*8 +: 8];
      if (bot[(2*j+1)*8 +: 8] > m) m = bot[(2*j+1)*8 +: 8];
      p[j*8 +: 8] = m;
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int iy, input int ich, input logic [223:0] row);
    i_run     = 1'b1;
    i_iy_idx  = 5'(iy);
    i_ich_idx = 3'(ich);
    i_ix_row  = row;
    tick();
    i_run     = 1'b0;
  endtask

  task automatic push(input int oy, input int och, input logic [111:0] data);
    exp_t e;
    e.oy   = 4'(oy);
    e.och  = 3'(och);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_idle"},    224'(o_idle),       224'(1));
    chk({tag, "_n_ready"}, 224'(o_n_ready),    224'(0));
    chk({tag, "_seq_err"}, 224'(o_seq_err),    224'(0));
    chk({tag, "_ovf_err"}, 224'(o_ovf_err),    224'(0));
    chk({tag, "_wr_run"},  224'(o_wr_run),     224'(0));
    chk({tag, "_oy"},      224'(o_wr_oy_idx),  224'(0));
    chk({tag, "_och"},     224'(o_wr_och_idx), 224'(0));
    chk({tag, "_pool"},    224'(o_wr_ox_pool), 224'(0));
  endtask

  always @(negedge clk) begin
    if (o_wr_run) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got oy=%0d och=%0d expected no pulse", o_wr_oy_idx, o_wr_och_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_oy",   224'(o_wr_oy_idx),  224'(e.oy));
        chk("pulse_och",  224'(o_wr_och_idx), 224'(e.och));
        chk("pulse_data", 224'(o_wr_ox_pool), 224'(e.data));
      end
    end
  end

  initial begin
    logic [223:0] top, bot;
    logic [111:0] exp1;

    areset    = 1'b1;
    i_run     = 1'b0;
    i_iy_idx  = '0;
    i_ich_idx = '0;
    i_ix_row  = '0;
    i_wr_idle = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    chk_reset_outputs("reset");

    // Pair pooling with the two-cycle pulse latency.
    for (int j = 0; j < 14; j++) exp1[j*8 +: 8] = 8'(((2*j+1) > (50-2*j)) ? (2*j+1) : (50-2*j));
    push(2, 2, exp1);
    send(4, 2, mk_row(0, 1));
    send(5, 2, mk_row(50, -1));
    chk("pair_n_ready_u1", 224'(o_n_ready),    224'(1));
    chk("pair_run_u1",     224'(o_wr_run),     224'(0));
    chk("pair_result_u1",  224'(o_wr_ox_pool), 224'(exp1));
    tick();
    chk("pair_run_u2",     224'(o_wr_run),  224'(1));
    chk("pair_n_ready_u2", 224'(o_n_ready), 224'(0));
    chk("pair_idle_u2",    224'(o_idle),    224'(0));
    tick();
    chk("pair_idle_after", 224'(o_idle), 224'(1));

    // Backpressure: writer busy for five cycles after the result loads.
    i_wr_idle = 1'b0;
    top = mk_row(200, 37);
    bot = mk_row(13, 91);
    push(4, 1, pool4(top, bot));
    send(8, 1, top);
    send(9, 1, bot);
    for (int c = 0; c < 5; c++) begin
      chk("bp_n_ready", 224'(o_n_ready), 224'(1));
      chk("bp_no_run",  224'(o_wr_run),  224'(0));
      tick();
    end
    i_wr_idle = 1'b1;
    chk("bp_n_ready_idle_cycle", 224'(o_n_ready), 224'(1));
    tick();
    chk("bp_run", 224'(o_wr_run), 224'(1));
    i_wr_idle = 1'b0;
    tick();
    chk("bp_single_run", 224'(o_wr_run), 224'(0));
    chk("bp_data_held",  224'(o_wr_ox_pool), 224'(pool4(top, bot)));
    i_wr_idle = 1'b1;

    // Full channel: 28 rows, one pulse per pair.
    for (int p = 0; p < 14; p++) begin
      top = mk_row(p*11, 5+p);
      bot = mk_row(255-p, -(3+p));
      push(p, 5, pool4(top, bot));
      i_run     = 1'b1;
      i_iy_idx  = 5'(2*p);
      i_ich_idx = 3'd5;
      i_ix_row  = top;
      tick();
      i_iy_idx  = 5'(2*p+1);
      i_ix_row  = bot;
      tick();
      i_run     = 1'b0;
      tick();
    end
    tick();
    chk("full_seq_err", 224'(o_seq_err), 224'(0));
    chk("full_ovf_err", 224'(o_ovf_err), 224'(0));
    chk("full_drained", 224'(exp_q.size()), 224'(0));

    // Sequencing errors.
    send(3, 0, mk_row(1, 1));
    chk("seq_odd_in_even", 224'(o_seq_err), 224'(1));
    chk("seq_even_stays",  224'(o_idle),    224'(1));
    send(6, 0, mk_row(2, 2));
    chk("seq_top_odd_state", 224'(o_idle), 224'(0));
    send(9, 0, mk_row(3, 3));
    chk("seq_mismatch_even", 224'(o_idle),   224'(1));
    tick();
    chk("seq_no_run", 224'(o_wr_run), 224'(0));
    top = mk_row(60, 9);
    bot = mk_row(250, -17);
    push(3, 0, pool4(top, bot));
    send(6, 0, top);
    send(30, 0, mk_row(255, 0));
    chk("seq_range_keeps_odd", 224'(o_idle), 224'(0));
    send(7, 0, bot);
    tick();
    tick();

    // Overflow while a result is pending.
    i_wr_idle = 1'b0;
    top = mk_row(100, 3);
    bot = mk_row(100, -3);
    push(5, 3, pool4(top, bot));
    send(10, 3, top);
    send(11, 3, bot);
    chk("ovf_clear_before", 224'(o_ovf_err), 224'(0));
    send(12, 3, mk_row(255, 0));
    chk("ovf_set",        224'(o_ovf_err),    224'(1));
    chk("ovf_n_ready",    224'(o_n_ready),    224'(1));
    chk("ovf_result_kept", 224'(o_wr_ox_pool), 224'(pool4(top, bot)));
    i_wr_idle = 1'b1;
    tick();
    tick();
    tick();
    chk("ovf_back_even", 224'(o_idle), 224'(1));

    // Reset while a result is pending discards it.
    i_wr_idle = 1'b0;
    send(0, 0, mk_row(9, 9));
    send(1, 0, mk_row(8, 8));
    chk("rst_pending", 224'(o_n_ready), 224'(1));
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk_reset_outputs("rst_mid");
    i_wr_idle = 1'b1;
    repeat (4) tick();
    chk("final_queue_empty", 224'(exp_q.size()), 224'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_pool_row.md
# max_pool_row

Row-streaming 2x2/stride-2 max-pool stage that sits directly upstream of the pooled-feature BRAM writer. It takes two consecutive conv/ReLU output rows of one channel, 2*OX unsigned features each, and produces one pooled row of OX features. It then issues that row to the writer with a run pulse plus the (oy, och) indices, holding it until the writer is idle. Sticky error flags catch sequencing and overflow violations by the upstream conv engine.

## Interface
- OCH, 6, number of channels
- OY, 14, pooled rows per channel; input rows per channel = 2*OY
- OX, 14, pooled features per row; input features per row = 2*OX
- F_BW, 8, feature width, unsigned (post-ReLU)
- clk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- i_run  in  1  single-cycle valid for one input row
- i_iy_idx  in  $clog2(2*OY) (5)  input row index
- i_ich_idx  in  $clog2(OCH) (3)  channel index
- i_ix_row  in  2*OX*F_BW (224)  input row; feature k at bits [k*F_BW +: F_BW]
- i_wr_idle  in  1  writer idle (writer o_idle)
- o_idle  out  1  high in S_EVEN with no pulse in flight
- o_n_ready  out  1  high in S_PEND; upstream must not assert i_run
- o_seq_err  out  1  sticky sequencing error
- o_ovf_err  out  1  sticky overflow error (i_run while o_n_ready)
- o_wr_run  out  1  single-cycle pulse to writer
- o_wr_oy_idx  out  $clog2(OY) (4)  pooled row index = iy>>1
- o_wr_och_idx  out  $clog2(OCH) (3)  channel index
- o_wr_ox_pool  out  OX*F_BW (112)  pooled row; feature j at bits [j*F_BW +: F_BW]

## Operation
- States: S_EVEN (wait top row), S_ODD (top held, wait bottom row), S_PEND (result held, wait writer).
- Horizontal max h[j] = max(in[2j], in[2j+1]). Unsigned compare. Ties yield the equal value.
- S_EVEN, i_run, iy even, indices in range: r_top <= h, store iy/ich, go to S_ODD.
- S_ODD, i_run, iy odd, iy == stored iy+1, ich == stored ich: result[j] <= max(h[j], r_top[j]); o_wr_oy_idx <= iy>>1; o_wr_och_idx <= ich; go to S_PEND.
- S_PEND, i_wr_idle=1: o_wr_run <= 1 for one cycle; go to S_EVEN. Result and indices are held unchanged through the pulse cycle and until the next result load.
- Error cases:
  - S_EVEN with odd iy: set o_seq_err, drop the row, stay in S_EVEN.
  - S_ODD with even iy: set o_seq_err, overwrite r_top and stored idx, stay in S_ODD.
  - S_ODD with odd iy but mismatched iy/ich: set o_seq_err, drop the row, go to S_EVEN.
  - iy >= 2*OY or ich >= OCH in any state: set o_seq_err, drop the row, state unchanged.
  - i_run in S_PEND: set o_ovf_err, drop the row, state and result unchanged.
- Error flags clear only on areset.
- Block is row-order agnostic across channels. Any valid pair is pooled independently.

## Timing
- Reset values: state S_EVEN, o_idle 1. All other outputs 0; r_top and result 0.
- Top row accepted at edge t: r_top valid from cycle t+1.
- The earliest legal bottom row is cycle t+1 (back-to-back rows allowed).
- Bottom row accepted at edge u: S_PEND and result valid in cycle u+1.
- o_n_ready is high from cycle u+1 until the cycle before o_wr_run.
- o_wr_run is high in cycle u+2 if i_wr_idle=1 in cycle u+1. Otherwise it rises one cycle after the first cycle i_wr_idle=1.
- Minimum row-pair-to-pulse latency: 2 cycles.
- o_n_ready is low and the state is S_EVEN during the o_wr_run cycle, so a new top row may arrive in that cycle.
- The next result cannot load before 2 cycles after the pulse, so writer capture is safe.
- i_wr_idle is only sampled in S_PEND. Its drop one cycle after the pulse never causes a double issue.
- Simultaneous i_run and the issue cycle in S_PEND: overflow rule applies, because o_n_ready is still high in that cycle.
- areset mid-operation: held top row and pending result are discarded, no pulse is issued, state returns to S_EVEN.

## Test plan
- Pair pooling: iy=4 row with in[k]=k, then iy=5 row with in[k]=50-k, och=2. Required: one o_wr_run 2 cycles later, oy=2, och=2, feature j = max(2j+1, 50-2j).
- Backpressure: hold i_wr_idle=0 for 5 cycles after the result loads. Required: o_n_ready=1 for those cycles, then o_wr_run exactly once one cycle after idle rises, with data unchanged.
- Full channel: 28 rows iy=0..27, och=5, back-to-back, i_wr_idle=1. Required: 14 pulses with oy 0..13, no error flags.
- Sequencing: iy=3 in S_EVEN; then iy=6 followed by iy=9. Required: o_seq_err=1, no pulse, state back to S_EVEN.
- Overflow: i_run while o_n_ready=1. Required: o_ovf_err=1, the pending result is issued intact, the offending row produces no output.
- Reset mid-S_PEND: Required: all outputs at reset values the next cycle, no o_wr_run.
